// File: rtl/pmod_keypad_scanner.sv
// 4x4 matrix keypad scanner for a PMOD header: column scan, full-matrix debounce,
// single-key press strobes and a two-digit BCD entry register for the 7-segment driver.
module pmod_keypad_scanner #(
  parameter int SCAN_TICKS     = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic [7:0] digits
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);

  logic [3:0]    row_meta, row_sync;
  logic [TW-1:0] tick;
  logic [1:0]    col_idx;
  logic [15:0]   snapshot, prev_snapshot, deb_state, snap_next;
  logic [CW-1:0] stable_cnt, cnt_next;
  logic          sample_now, scan_end, snap_onehot;
  logic [3:0]    first_idx;
  logic          press_pending;
  logic [3:0]    pending_code;

  function automatic logic [3:0] key_label(input logic [3:0] idx);
    case (idx)
      4'd0:  key_label = 4'h1;
      4'd1:  key_label = 4'h2;
      4'd2:  key_label = 4'h3;
      4'd3:  key_label = 4'hA;
      4'd4:  key_label = 4'h4;
      4'd5:  key_label = 4'h5;
      4'd6:  key_label = 4'h6;
      4'd7:  key_label = 4'hB;
      4'd8:  key_label = 4'h7;
      4'd9:  key_label = 4'h8;
      4'd10: key_label = 4'h9;
      4'd11: key_label = 4'hC;
      4'd12: key_label = 4'h0;
      4'd13: key_label = 4'hF;
      4'd14: key_label = 4'hE;
      default: key_label = 4'hD;
    endcase
  endfunction

  assign col        = ~(4'b0001 << col_idx);
  assign sample_now = (tick == TICK_LAST);
  assign scan_end   = sample_now && (col_idx == 2'd3);

  // Snapshot as it will look after this cycle's sample, so the end-of-scan
  // compare sees column 3 without waiting an extra cycle.
  always_comb begin
    snap_next = snapshot;
    for (int r = 0; r < 4; r++) begin
      snap_next[4*r + int'(col_idx)] = ~row_sync[r];
    end
  end

  always_comb begin
    cnt_next = '0;
    if (snap_next == prev_snapshot) begin
      cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
    end
  end

  always_comb begin
    snap_onehot = (snap_next != '0) && ((snap_next & (snap_next - 16'd1)) == '0);
    first_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_next[i]) first_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      tick     <= '0;
      col_idx  <= '0;
      snapshot <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (sample_now) begin
        tick     <= '0;
        col_idx  <= col_idx + 2'd1;
        snapshot <= snap_next;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // Debounce: the whole matrix must repeat for DEBOUNCE_SCANS scans before it is trusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snapshot <= '0;
      stable_cnt    <= '0;
      deb_state     <= '0;
      key_down      <= 1'b0;
      press_pending <= 1'b0;
      pending_code  <= '0;
    end else begin
      press_pending <= 1'b0;
      if (scan_end) begin
        stable_cnt    <= cnt_next;
        prev_snapshot <= snap_next;
        if (cnt_next == CNT_MAX) begin
          deb_state <= snap_next;
          key_down  <= (snap_next != '0);
          if ((deb_state == '0) && snap_onehot) begin
            press_pending <= 1'b1;
            pending_code  <= key_label(first_idx);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      digits    <= '0;
    end else begin
      key_valid <= press_pending;
      if (press_pending) begin
        key_code <= pending_code;
        if (pending_code <= 4'd9) begin
          digits <= {digits[3:0], pending_code};
        end else if (pending_code == 4'hC) begin
          digits <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmod_keypad_scanner.sv
// Directed bench for pmod_keypad_scanner with a behavioural keypad matrix model.
module tb_pmod_keypad_scanner;

  localparam int ST = 4;
  localparam int DS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col, row, key_code;
  logic       key_valid, key_down;
  logic [7:0] digits;
  logic [15:0] keys = '0;

  int errors = 0;
  int checks = 0;
  int valid_count = 0;
  logic [3:0] last_code = '0;

  pmod_keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .digits(digits)
  );

  always #5 clk = ~clk;

  // Key (r,c) shorts row r to column c; rows are pulled up otherwise.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(keys[4*r +: 4] & ~col);
    end
  end

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) begin
      valid_count++;
      last_code = key_code;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_strobe(input int base, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid_count != base) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int limit, output bit got);
    keys = '0;
    got  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (key_down === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
    checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col got=%b exp=1110", col); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", key_valid); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL reset_down got=%b exp=0", key_down); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code got=%h exp=0", key_code); end
    checks++; if (digits !== 8'h00) begin errors++; $display("[TB] FAIL reset_digits got=%h exp=00", digits); end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << (k / 4));
      checks++;
      if (col !== exp_col) begin errors++; $display("[TB] FAIL col_rotate k=%0d got=%b exp=%b", k, col, exp_col); end
      @(negedge clk);
    end
    repeat (144) @(negedge clk);
    checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL col_after_10_scans got=%b exp=1110", col); end
    checks++; if (valid_count != 0) begin errors++; $display("[TB] FAIL idle_strobes got=%0d exp=0", valid_count); end
    checks++; if (digits !== 8'h00) begin errors++; $display("[TB] FAIL idle_digits got=%h exp=00", digits); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL idle_down got=%b exp=0", key_down); end
  endtask

  task automatic test_single_press;
    int base;
    bit got;
    base = valid_count;
    keys = '0;
    keys[5] = 1'b1;
    wait_strobe(base, 68, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL press5_latency got=none exp=strobe within 68 cycles"); end
    checks++; if (last_code !== 4'h5) begin errors++; $display("[TB] FAIL press5_code got=%h exp=5", last_code); end
    checks++; if (digits !== 8'h05) begin errors++; $display("[TB] FAIL press5_digits got=%h exp=05", digits); end
    checks++; if (key_down !== 1'b1) begin errors++; $display("[TB] FAIL press5_down got=%b exp=1", key_down); end
    repeat (100) @(negedge clk);
    checks++; if (valid_count != base + 1) begin errors++; $display("[TB] FAIL press5_count got=%0d exp=%0d", valid_count - base, 1); end
    checks++; if (key_down !== 1'b1) begin errors++; $display("[TB] FAIL press5_held_down got=%b exp=1", key_down); end
    wait_release(80, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL release5 got=key_down stuck exp=0 within 80 cycles"); end
    repeat (40) @(negedge clk);
    checks++; if (valid_count != base + 1) begin errors++; $display("[TB] FAIL release5_count got=%0d exp=1", valid_count - base); end
    checks++; if (digits !== 8'h05) begin errors++; $display("[TB] FAIL release5_digits got=%h exp=05", digits); end
  endtask

  task automatic test_back_to_back;
    int base;
    bit got;
    base = valid_count;
    keys = '0; keys[4] = 1'b1;
    wait_strobe(base, 68, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL press4_latency got=none exp=strobe"); end
    checks++; if (last_code !== 4'h4) begin errors++; $display("[TB] FAIL press4_code got=%h exp=4", last_code); end
    checks++; if (digits !== 8'h54) begin errors++; $display("[TB] FAIL press4_digits got=%h exp=54", digits); end
    repeat (20) @(negedge clk);
    wait_release(80, got);
    keys = '0; keys[1] = 1'b1;
    wait_strobe(base + 1, 68, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL press2_latency got=none exp=strobe"); end
    checks++; if (last_code !== 4'h2) begin errors++; $display("[TB] FAIL press2_code got=%h exp=2", last_code); end
    checks++; if (digits !== 8'h42) begin errors++; $display("[TB] FAIL press2_digits got=%h exp=42", digits); end
    repeat (20) @(negedge clk);
    wait_release(80, got);
    keys = '0; keys[11] = 1'b1;
    wait_strobe(base + 2, 68, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL pressC_latency got=none exp=strobe"); end
    checks++; if (last_code !== 4'hC) begin errors++; $display("[TB] FAIL pressC_code got=%h exp=C", last_code); end
    checks++; if (digits !== 8'h00) begin errors++; $display("[TB] FAIL pressC_digits got=%h exp=00", digits); end
    repeat (20) @(negedge clk);
    wait_release(80, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL releaseC got=key_down stuck exp=0"); end
    checks++; if (valid_count != base + 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", valid_count - base); end
  endtask

  task automatic test_bounce;
    int base;
    bit got;
    base = valid_count;
    keys = '0;
    for (int t = 0; t < 5; t++) begin
      keys[8] = (t % 2 == 0);
      repeat (10) @(negedge clk);
    end
    keys[8] = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (valid_count != base + 1) begin errors++; $display("[TB] FAIL bounce_count got=%0d exp=1", valid_count - base); end
    checks++; if (last_code !== 4'h7) begin errors++; $display("[TB] FAIL bounce_code got=%h exp=7", last_code); end
    checks++; if (key_down !== 1'b1) begin errors++; $display("[TB] FAIL bounce_down got=%b exp=1", key_down); end
    wait_release(80, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL bounce_release got=key_down stuck exp=0"); end
  endtask

  task automatic test_multi_key;
    int base;
    bit got;
    base = valid_count;
    keys = '0; keys[0] = 1'b1; keys[1] = 1'b1;
    repeat (96) @(negedge clk);
    checks++; if (valid_count != base) begin errors++; $display("[TB] FAIL multi_count got=%0d exp=0", valid_count - base); end
    checks++; if (key_down !== 1'b1) begin errors++; $display("[TB] FAIL multi_down got=%b exp=1", key_down); end
    checks++; if (key_code !== 4'h7) begin errors++; $display("[TB] FAIL multi_code got=%h exp=7", key_code); end
    keys[1] = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (valid_count != base) begin errors++; $display("[TB] FAIL multi_to_single_count got=%0d exp=0", valid_count - base); end
    checks++; if (key_down !== 1'b1) begin errors++; $display("[TB] FAIL multi_to_single_down got=%b exp=1", key_down); end
    checks++; if (key_code !== 4'h7) begin errors++; $display("[TB] FAIL multi_to_single_code got=%h exp=7", key_code); end
    wait_release(80, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL multi_release got=key_down stuck exp=0"); end
  endtask

  task automatic test_reset_mid_debounce;
    int base;
    bit got;
    base = valid_count;
    keys = '0; keys[10] = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (valid_count != base) begin errors++; $display("[TB] FAIL early9_count got=%0d exp=0", valid_count - base); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL midrst_col got=%b exp=1110", col); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%b exp=0", key_valid); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL midrst_down got=%b exp=0", key_down); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL midrst_code got=%h exp=0", key_code); end
    checks++; if (digits !== 8'h00) begin errors++; $display("[TB] FAIL midrst_digits got=%h exp=00", digits); end
    rst  = 1'b0;
    base = valid_count;
    wait_strobe(base, 68, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL press9_latency got=none exp=strobe within 68 cycles"); end
    checks++; if (last_code !== 4'h9) begin errors++; $display("[TB] FAIL press9_code got=%h exp=9", last_code); end
    checks++; if (digits !== 8'h09) begin errors++; $display("[TB] FAIL press9_digits got=%h exp=09", digits); end
    wait_release(80, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL release9 got=key_down stuck exp=0"); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_back_to_back();
    test_bounce();
    test_multi_key();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
